if_fetch_queue: RTL and testbench
=================================

Name: if_fetch_queue

Overview:
- Small FIFO of fetched instructions between the fetch stage and the ID stage.
- Each entry holds the fetch-stage outputs pc, pc+4 and instruction word, plus the predicted-taken bit.
- Decouples ID back-pressure from fetch timing and drops all wrong-path instructions in one cycle on a redirect.
- Upstream side is a valid/ready handshake from fetch; downstream side is a valid/ready handshake into ID.

Parameters:
DEPTH, 4, number of entries; power of two, at least 2.
NOP_INSTR, 32'h0000_0013, instruction word driven to ID when the queue is empty (addi x0,x0,0).

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
flush  in  1  redirect (EX mispredict or ID predicted-taken); discard all entries
if_valid  in  1  fetch offers an entry this cycle
if_ready  out  1  queue accepts an entry this cycle
if_pc  in  32  PC of the offered instruction
if_pc_p4  in  32  PC+4 of the offered instruction
if_instr  in  32  offered instruction word
if_pred_taken  in  1  ID branch-predictor decision attached to the entry
id_valid  out  1  head entry is valid
id_ready  in  1  ID consumes the head this cycle
id_pc  out  32  head PC
id_pc_p4  out  32  head PC+4
id_instr  out  32  head instruction word
id_pred_taken  out  1  head predicted-taken bit
count  out  $clog2(DEPTH+1)  current occupancy, 0..DEPTH

Behaviour:
- Reset (rst high at posedge): wr_ptr=0, rd_ptr=0, count=0.
  - Storage contents are don't-care.
  - After the edge: id_valid=0, if_ready=1, id_pc=0, id_pc_p4=0, id_instr=NOP_INSTR, id_pred_taken=0.
  - rst has priority over every other input.
- Push = if_valid && if_ready.
  - Writes {if_pc, if_pc_p4, if_instr, if_pred_taken} at wr_ptr.
  - wr_ptr increments modulo DEPTH.
- Pop = id_valid && id_ready. rd_ptr increments modulo DEPTH.
- if_ready = (count != DEPTH).
  - Depends only on registered state; no combinational path from id_ready.
  - When full, a same-cycle pop does not open the upstream side.
- id_valid = (count != 0).
  - id_* are driven from storage at rd_ptr (combinational read of registers).
  - When empty: id_pc=0, id_pc_p4=0, id_instr=NOP_INSTR, id_pred_taken=0.
- Latency: no bypass. An entry pushed at edge N is first visible on id_* during cycle N+1 (minimum 1 cycle).
- Count update:
  - push only: +1
  - pop only: -1
  - push and pop together: unchanged; both pointers advance.
  - Push and pop together is legal when 0 < count < DEPTH.
- Pointer width: $clog2(DEPTH) bits; wrap is natural overflow.
  - count is kept separately, so full and empty are unambiguous when wr_ptr == rd_ptr.
- Flush (rst low):
  - At the edge: wr_ptr=0, rd_ptr=0, count=0.
  - A push in the same cycle is discarded, so the wrong-path instruction is dropped.
  - A pop in the same cycle still counts as a handshake for ID's bookkeeping, but has no effect on queue state.
  - During the flush cycle, id_* still reflect the pre-flush head; ID is responsible for squashing.
  - Cycle after flush: id_valid=0, if_ready=1.
- Overflow and underflow are impossible by construction.
  - Assertion: never push when count==DEPTH.
  - Assertion: never pop when count==0.
- Reset mid-operation behaves exactly like flush, and additionally forces the output values listed above.

Decomposition:
- Shared package if_pkg holds:
  - typedef fetch_entry_t, a packed struct {pc[31:0], pc_p4[31:0], instr[31:0], pred_taken}, 97 bits.
  - Constant NOP_INSTR = 32'h0000_0013.
- The fetch stage and ID stage import the same struct.
- One natural sub-module: fifo_ctrl, which owns the pointers, count and full/empty generation.
  - Storage array and output muxing stay in if_fetch_queue.

Test Plan:
1. Reset then idle: rst=1 for 2 cycles, then 0 → id_valid=0, if_ready=1, count=0, id_instr=32'h00000013, id_pc=0.
2. Single push: if_valid=1, if_pc=0x100, if_pc_p4=0x104, if_instr=0x00500093, one cycle, id_ready=0 → next cycle id_valid=1, id_pc=0x100, id_instr=0x00500093, count=1; then id_ready=1 for one cycle → id_valid=0, count=0.
3. Fill and full: push PCs 0x0,0x4,0x8,0xC with id_ready=0 → count=4, if_ready=0. Fifth offer (0x10) held → not stored. Pop one → next cycle if_ready=1, and 0x10 is accepted after it.
4. Wrap and simultaneous push/pop: steady stream of 10 pushes with id_ready=1 and DEPTH=4 → id_pc sequence 0x0..0x24 in order, none lost, count stays 1 in steady state, pointers wrap twice.
5. Flush with concurrent push: count=3 (0x20,0x24,0x28), flush=1 together with a push of 0x2C → next cycle count=0, id_valid=0. A subsequent push of 0x80 appears as the next head, and 0x2C never appears.
6. Reset mid-stream: count=2, assert rst together with if_valid=1 and id_ready=1 → next cycle count=0, id_valid=0, id_instr=NOP_INSTR; pushed entry discarded.

Source files
------------

// File: rtl/if_pkg.sv
// Types and constants shared by the fetch stage, the fetch queue and the ID stage.
package if_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc_p4;
        logic [31:0] instr;
        logic        pred_taken;
    } fetch_entry_t;

endpackage

// File: rtl/if_fetch_queue_fifo_ctrl.sv
// Pointer and occupancy bookkeeping for the fetch queue; full/empty come from
// the separate count, so wr_ptr == rd_ptr is never ambiguous.
module fifo_ctrl #(
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    output logic [$clog2(DEPTH)-1:0]   wr_ptr_o,
    output logic [$clog2(DEPTH)-1:0]   rd_ptr_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       full_o,
    output logic                       empty_o
);
    import if_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Next-state: a flush drops everything, including a same-cycle push or pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = {PTR_W{1'b0}};
            rd_ptr_d = {PTR_W{1'b0}};
            count_d  = {CNT_W{1'b0}};
        end else begin
            if (push_i) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_i) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_i, pop_i})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign wr_ptr_o = wr_ptr_q;
    assign rd_ptr_o = rd_ptr_q;
    assign count_o  = count_q;
    assign full_o   = (count_q == CNT_W'(DEPTH));
    assign empty_o  = (count_q == {CNT_W{1'b0}});

endmodule

// File: rtl/if_fetch_queue_sva.sv
// Protocol checker for the fetch queue: the handshakes must never over- or underflow it.
module if_fetch_queue_sva #(
    parameter int DEPTH = 4
) (
    input logic                       clk,
    input logic                       rst,
    input logic                       push,
    input logic                       pop,
    input logic [$clog2(DEPTH+1)-1:0] count
);

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && (count == ($clog2(DEPTH+1))'(DEPTH))));

    a_no_underflow: assert property (@(posedge clk) disable iff (rst)
        !(pop && (count == ($clog2(DEPTH+1))'(0))));

endmodule

// File: rtl/if_fetch_queue.sv
// Fetch-to-ID instruction queue: entry storage and head output muxing around fifo_ctrl.
// Upstream ready depends only on registered occupancy, never on id_ready.
module if_fetch_queue #(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] NOP_INSTR = if_pkg::NOP_INSTR
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       if_valid,
    output logic                       if_ready,
    input  logic [31:0]                if_pc,
    input  logic [31:0]                if_pc_p4,
    input  logic [31:0]                if_instr,
    input  logic                       if_pred_taken,
    output logic                       id_valid,
    input  logic                       id_ready,
    output logic [31:0]                id_pc,
    output logic [31:0]                id_pc_p4,
    output logic [31:0]                id_instr,
    output logic                       id_pred_taken,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    import if_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);

    fetch_entry_t     mem_q [DEPTH];
    fetch_entry_t     entry_in_s;
    fetch_entry_t     head_s;
    logic [PTR_W-1:0] wr_ptr_s;
    logic [PTR_W-1:0] rd_ptr_s;
    logic             full_s;
    logic             empty_s;
    logic             push_s;
    logic             pop_s;

    assign if_ready = !full_s;
    assign id_valid = !empty_s;
    assign push_s   = if_valid && if_ready;
    assign pop_s    = id_valid && id_ready;

    assign entry_in_s = '{pc: if_pc, pc_p4: if_pc_p4, instr: if_instr, pred_taken: if_pred_taken};

    fifo_ctrl #(.DEPTH(DEPTH)) u_ctrl (
        .clk_i    (clk),
        .rst_i    (rst),
        .flush_i  (flush),
        .push_i   (push_s),
        .pop_i    (pop_s),
        .wr_ptr_o (wr_ptr_s),
        .rd_ptr_o (rd_ptr_s),
        .count_o  (count),
        .full_o   (full_s),
        .empty_o  (empty_s)
    );

    // Entry storage; a write during flush is harmless because the pointers restart.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_s] <= entry_in_s;
        end
    end

    // Head output: the stored entry when occupied, otherwise a bubble NOP.
    always_comb begin
        head_s        = mem_q[rd_ptr_s];
        id_pc         = 32'h0000_0000;
        id_pc_p4      = 32'h0000_0000;
        id_instr      = NOP_INSTR;
        id_pred_taken = 1'b0;
        if (!empty_s) begin
            id_pc         = head_s.pc;
            id_pc_p4      = head_s.pc_p4;
            id_instr      = head_s.instr;
            id_pred_taken = head_s.pred_taken;
        end else begin
            id_pc         = 32'h0000_0000;
            id_pc_p4      = 32'h0000_0000;
            id_instr      = NOP_INSTR;
            id_pred_taken = 1'b0;
        end
    end

    if_fetch_queue_sva #(.DEPTH(DEPTH)) u_sva (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .pop   (pop_s),
        .count (count)
    );

endmodule

// File: tb/tb_if_fetch_queue.sv
// Self-checking bench for if_fetch_queue: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_if_fetch_queue;
    import if_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst, flush, if_valid, id_ready, if_pred_taken;
    logic        if_ready, id_valid, id_pred_taken;
    logic [31:0] if_pc, if_pc_p4, if_instr, id_pc, id_pc_p4, id_instr;
    logic [2:0]  count;

    int pass_cnt = 0;
    int total_cnt = 0;
    fetch_entry_t model_q[$];

    always #5 clk = ~clk;

    if_fetch_queue #(.DEPTH(DEPTH), .NOP_INSTR(NOP_INSTR)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_pc_p4(if_pc_p4),
        .if_instr(if_instr), .if_pred_taken(if_pred_taken),
        .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc), .id_pc_p4(id_pc_p4),
        .id_instr(id_instr), .id_pred_taken(id_pred_taken), .count(count)
    );

    // One clock: model applies the handshake rules at the edge, then we sit at negedge.
    task automatic tick();
        bit do_push, do_pop;
        fetch_entry_t e;
        do_push = if_valid && (model_q.size() != DEPTH);
        do_pop  = id_ready && (model_q.size() != 0);
        e = '{pc: if_pc, pc_p4: if_pc_p4, instr: if_instr, pred_taken: if_pred_taken};
        @(posedge clk);
        if (rst || flush) begin
            model_q.delete();
        end else begin
            if (do_pop) void'(model_q.pop_front());
            if (do_push) model_q.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic offer(input logic [31:0] pc);
        if_valid = 1'b1; if_pc = pc; if_pc_p4 = pc + 32'd4;
        if_instr = pc ^ 32'h0A50_0013; if_pred_taken = pc[2];
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; if_valid = 1'b0; id_ready = 1'b0;
        if_pc = 32'h0; if_pc_p4 = 32'h0; if_instr = 32'h0; if_pred_taken = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();
        total_cnt++; if (id_valid !== 1'b0) $display("FAIL reset_id_valid: got %b expected 0", id_valid); else pass_cnt++;
        total_cnt++; if (if_ready !== 1'b1) $display("FAIL reset_if_ready: got %b expected 1", if_ready); else pass_cnt++;
        total_cnt++; if (count !== 3'd0) $display("FAIL reset_count: got %0d expected 0", count); else pass_cnt++;
        total_cnt++; if (id_instr !== 32'h0000_0013) $display("FAIL reset_id_instr: got %h expected 00000013", id_instr); else pass_cnt++;
        total_cnt++; if (id_pc !== 32'h0 || id_pc_p4 !== 32'h0 || id_pred_taken !== 1'b0)
            $display("FAIL reset_id_fields: got pc=%h p4=%h pt=%b expected zeros", id_pc, id_pc_p4, id_pred_taken); else pass_cnt++;
    endtask

    task automatic test_single_push();
        if_valid = 1'b1; if_pc = 32'h100; if_pc_p4 = 32'h104; if_instr = 32'h0050_0093; if_pred_taken = 1'b1;
        id_ready = 1'b0;
        tick();
        if_valid = 1'b0;
        total_cnt++; if (id_valid !== 1'b1 || count !== 3'd1) $display("FAIL single_valid: got v=%b cnt=%0d expected v=1 cnt=1", id_valid, count); else pass_cnt++;
        total_cnt++; if (id_pc !== 32'h100 || id_pc_p4 !== 32'h104) $display("FAIL single_pc: got %h/%h expected 00000100/00000104", id_pc, id_pc_p4); else pass_cnt++;
        total_cnt++; if (id_instr !== 32'h0050_0093 || id_pred_taken !== 1'b1) $display("FAIL single_instr: got %h pt=%b expected 00500093 pt=1", id_instr, id_pred_taken); else pass_cnt++;
        id_ready = 1'b1;
        tick();
        id_ready = 1'b0;
        total_cnt++; if (id_valid !== 1'b0 || count !== 3'd0) $display("FAIL single_pop: got v=%b cnt=%0d expected v=0 cnt=0", id_valid, count); else pass_cnt++;
    endtask

    task automatic test_fill_full();
        logic [31:0] exp_pc;
        id_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            offer(32'(i * 4));
            tick();
        end
        if_valid = 1'b0;
        total_cnt++; if (count !== 3'd4 || if_ready !== 1'b0) $display("FAIL full_state: got cnt=%0d rdy=%b expected cnt=4 rdy=0", count, if_ready); else pass_cnt++;
        offer(32'h10);
        tick();
        total_cnt++; if (count !== 3'd4 || id_pc !== 32'h0) $display("FAIL full_held: got cnt=%0d pc=%h expected cnt=4 pc=0", count, id_pc); else pass_cnt++;
        // pop while full with offer still up: upstream must not open this cycle
        id_ready = 1'b1;
        tick();
        id_ready = 1'b0;
        total_cnt++; if (count !== 3'd3 || if_ready !== 1'b1 || id_pc !== 32'h4)
            $display("FAIL full_pop: got cnt=%0d rdy=%b pc=%h expected cnt=3 rdy=1 pc=4", count, if_ready, id_pc); else pass_cnt++;
        tick();
        if_valid = 1'b0;
        total_cnt++; if (count !== 3'd4) $display("FAIL full_accept: got cnt=%0d expected 4", count); else pass_cnt++;
        id_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_pc = 32'(4 + i * 4);
            total_cnt++; if (id_pc !== exp_pc) $display("FAIL full_drain[%0d]: got %h expected %h", i, id_pc, exp_pc); else pass_cnt++;
            tick();
        end
        id_ready = 1'b0;
        total_cnt++; if (id_valid !== 1'b0) $display("FAIL full_empty: got %b expected 0", id_valid); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] popped[$];
        logic [31:0] exp_pc;
        id_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            offer(32'(i * 4));
            if (id_valid) popped.push_back(id_pc);
            tick();
            exp_pc = 32'(i * 4);
            total_cnt++; if (count !== 3'd1 || id_pc !== exp_pc)
                $display("FAIL b2b_step[%0d]: got cnt=%0d pc=%h expected cnt=1 pc=%h", i, count, id_pc, exp_pc); else pass_cnt++;
        end
        if_valid = 1'b0;
        if (id_valid) popped.push_back(id_pc);
        tick();
        id_ready = 1'b0;
        total_cnt++; if (popped.size() != 10) $display("FAIL b2b_len: got %0d expected 10", popped.size()); else pass_cnt++;
        for (int i = 0; i < popped.size() && i < 10; i++) begin
            exp_pc = 32'(i * 4);
            total_cnt++; if (popped[i] !== exp_pc) $display("FAIL b2b_order[%0d]: got %h expected %h", i, popped[i], exp_pc); else pass_cnt++;
        end
    endtask

    task automatic test_flush();
        id_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            offer(32'h20 + 32'(i * 4));
            tick();
        end
        total_cnt++; if (count !== 3'd3) $display("FAIL flush_pre: got cnt=%0d expected 3", count); else pass_cnt++;
        flush = 1'b1; offer(32'h2C); id_ready = 1'b1;
        #1;
        total_cnt++; if (id_valid !== 1'b1 || id_pc !== 32'h20) $display("FAIL flush_head: got v=%b pc=%h expected v=1 pc=20", id_valid, id_pc); else pass_cnt++;
        tick();
        flush = 1'b0; if_valid = 1'b0; id_ready = 1'b0;
        total_cnt++; if (count !== 3'd0 || id_valid !== 1'b0 || if_ready !== 1'b1)
            $display("FAIL flush_after: got cnt=%0d v=%b rdy=%b expected 0/0/1", count, id_valid, if_ready); else pass_cnt++;
        offer(32'h80);
        tick();
        if_valid = 1'b0;
        total_cnt++; if (id_pc !== 32'h80 || count !== 3'd1) $display("FAIL flush_next: got pc=%h cnt=%0d expected pc=80 cnt=1", id_pc, count); else pass_cnt++;
        id_ready = 1'b1;
        tick();
        id_ready = 1'b0;
        total_cnt++; if (id_valid !== 1'b0) $display("FAIL flush_no2c: got v=%b pc=%h expected empty", id_valid, id_pc); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        id_ready = 1'b0;
        offer(32'h300); tick();
        offer(32'h304); tick();
        total_cnt++; if (count !== 3'd2) $display("FAIL rstmid_pre: got cnt=%0d expected 2", count); else pass_cnt++;
        rst = 1'b1; offer(32'h308); id_ready = 1'b1;
        tick();
        rst = 1'b0; if_valid = 1'b0; id_ready = 1'b0;
        total_cnt++; if (count !== 3'd0 || id_valid !== 1'b0 || id_instr !== NOP_INSTR || id_pc !== 32'h0)
            $display("FAIL rstmid_after: got cnt=%0d v=%b instr=%h pc=%h expected 0/0/00000013/0", count, id_valid, id_instr, id_pc); else pass_cnt++;
    endtask

    task automatic test_random();
        fetch_entry_t exp;
        int           exp_cnt;
        for (int c = 0; c < 400; c++) begin
            rst      = ($urandom_range(63) == 0);
            flush    = ($urandom_range(15) == 0);
            id_ready = $urandom_range(1);
            if_valid = ($urandom_range(3) != 0);
            if_pc    = $urandom & 32'hFFFF_FFFC;
            if_pc_p4 = if_pc + 32'd4;
            if_instr = $urandom;
            if_pred_taken = $urandom_range(1);
            #1;
            exp_cnt = model_q.size();
            if (exp_cnt != 0) exp = model_q[0];
            else exp = '{pc: 32'h0, pc_p4: 32'h0, instr: NOP_INSTR, pred_taken: 1'b0};
            total_cnt++;
            if (count !== 3'(exp_cnt) || id_valid !== (exp_cnt != 0) || if_ready !== (exp_cnt != DEPTH) ||
                id_pc !== exp.pc || id_pc_p4 !== exp.pc_p4 || id_instr !== exp.instr || id_pred_taken !== exp.pred_taken)
                $display("FAIL random[%0d]: got cnt=%0d v=%b r=%b pc=%h p4=%h in=%h pt=%b expected cnt=%0d pc=%h p4=%h in=%h pt=%b",
                         c, count, id_valid, if_ready, id_pc, id_pc_p4, id_instr, id_pred_taken,
                         exp_cnt, exp.pc, exp.pc_p4, exp.instr, exp.pred_taken);
            else pass_cnt++;
            tick();
        end
        rst = 1'b0; flush = 1'b0; if_valid = 1'b0; id_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_push();
        test_fill_full();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
